// File: rtl/chbuf_ctrl.sv
// chbuf_ctrl: bus-register front end that writes characters into a character
// buffer. It provides a pointer register and single/auto-increment writes.
// It also has an optional fill engine that streams a fill character into N
// consecutive locations.
// The fill engine is built only when the macro CHBUF_FILL_EN is defined.
// Without it the design keeps just the pointer and single-write paths.
// CB_AW must not exceed 16 so that the pointer fits the 16-bit read bus.
module chbuf_ctrl #(
    parameter int CB_AW = 14
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             do_write,
    input  logic [7:0]       w_adr,
    input  logic [15:0]      w_data,
    input  logic [7:0]       r_adr,
    output logic [15:0]      read_data,
    output logic             chbuf_w,
    output logic [CB_AW-1:0] chbuf_adr,
    output logic [7:0]       chbuf_data,
    output logic             busy
);

    localparam logic [7:0] ADR_PTR = 8'h00;
    localparam logic [7:0] ADR_WR  = 8'h02;
    localparam logic [7:0] ADR_WRI = 8'h03;

    // Bus write decode shared by both builds
    logic wr_ptr;
    logic wr_one;
    logic wr_inc;
    assign wr_ptr = do_write && (w_adr == ADR_PTR);
    assign wr_one = do_write && (w_adr == ADR_WR);
    assign wr_inc = do_write && (w_adr == ADR_WRI);

    // Not every data bit is consumed (e.g. bit 15, upper pointer bits)
    logic unused_wdata;
    assign unused_wdata = ^w_data;

    logic [CB_AW-1:0] ptr;
    logic [CB_AW-1:0] ptr_nxt;
    logic             wr_en_nxt;
    logic [CB_AW-1:0] wr_adr_nxt;
    logic [7:0]       wr_data_nxt;

    // Pointer and registered buffer-write port; everything clears on reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr        <= '0;
            chbuf_w    <= 1'b0;
            chbuf_adr  <= '0;
            chbuf_data <= '0;
        end else begin
            ptr        <= ptr_nxt;
            chbuf_w    <= wr_en_nxt;
            chbuf_adr  <= wr_adr_nxt;
            chbuf_data <= wr_data_nxt;
        end
    end

`ifdef CHBUF_FILL_EN
    localparam logic [7:0] ADR_FCH  = 8'h04;
    localparam logic [7:0] ADR_FILL = 8'h05;
    localparam logic [7:0] ADR_STAT = 8'h06;
    localparam logic [7:0] ADR_CTRL = 8'h07;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  fch;
    logic [7:0]  fch_nxt;
    logic [14:0] rem;
    logic [14:0] rem_nxt;
    logic        ovr;
    logic        ovr_nxt;
    logic        busy_r;
    logic        busy_nxt;

    logic wr_fch;
    logic wr_fill;
    logic wr_ctrl;
    logic fill_req;
    logic abort_req;
    logic ovr_clr;
    logic last_fill;
    logic bus_hit;

    assign wr_fch    = do_write && (w_adr == ADR_FCH);
    assign wr_fill   = do_write && (w_adr == ADR_FILL);
    assign wr_ctrl   = do_write && (w_adr == ADR_CTRL);
    assign fill_req  = wr_fill && (w_data[14:0] != 15'd0);
    assign abort_req = wr_ctrl && w_data[0];
    assign ovr_clr   = wr_ctrl && w_data[1];
    // The write issued at this edge is the last one of the fill
    assign last_fill = (rem == 15'd1);
    // Any register write that the engine cannot honour while filling
    assign bus_hit   = wr_ptr || wr_one || wr_inc || wr_fch || wr_fill;

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a fill ends on its last write or on an abort
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fill_req) state_nxt = S_FILL;
            S_FILL:  if (last_fill || abort_req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: register updates and the next buffer write
    always_comb begin
        ptr_nxt     = ptr;
        fch_nxt     = fch;
        rem_nxt     = rem;
        ovr_nxt     = ovr;
        busy_nxt    = 1'b0;
        wr_en_nxt   = 1'b0;
        wr_adr_nxt  = chbuf_adr;
        wr_data_nxt = chbuf_data;
        case (state)
            S_IDLE: begin
                if (wr_ptr) ptr_nxt = w_data[CB_AW-1:0];
                if (wr_one || wr_inc) begin
                    wr_en_nxt   = 1'b1;
                    wr_adr_nxt  = ptr;
                    wr_data_nxt = w_data[7:0];
                end
                if (wr_inc) ptr_nxt = ptr + 1'b1;
                if (wr_fch) fch_nxt = w_data[7:0];
                if (fill_req) rem_nxt = w_data[14:0];
            end
            S_FILL: begin
                // An abort landing on the final write lets that write
                // complete, so it is indistinguishable from normal completion
                if (abort_req && !last_fill) begin
                    rem_nxt = '0;
                end else begin
                    wr_en_nxt   = 1'b1;
                    busy_nxt    = 1'b1;
                    wr_adr_nxt  = ptr;
                    wr_data_nxt = fch;
                    ptr_nxt     = ptr + 1'b1;
                    rem_nxt     = rem - 1'b1;
                end
                if (bus_hit) ovr_nxt = 1'b1;
            end
            default: ;
        endcase
        // Clearing takes priority over a simultaneous overrun
        if (ovr_clr) ovr_nxt = 1'b0;
    end

    // Fill-engine registers; busy is aligned with the fill's chbuf_w pulses
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fch    <= '0;
            rem    <= '0;
            ovr    <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            fch    <= fch_nxt;
            rem    <= rem_nxt;
            ovr    <= ovr_nxt;
            busy_r <= busy_nxt;
        end
    end

    assign busy = busy_r;

    // Register read decode; reads have no side effects
    always_comb begin
        read_data = '0;
        case (r_adr)
            ADR_PTR:  read_data = 16'(ptr);
            ADR_FCH:  read_data = {8'h00, fch};
            ADR_FILL: read_data = {1'b0, rem};
            ADR_STAT: read_data = {14'h0000, ovr, busy_r};
            default:  read_data = '0;
        endcase
    end
`else
    // Pointer load and single/auto-increment writes only
    always_comb begin
        ptr_nxt     = ptr;
        wr_en_nxt   = 1'b0;
        wr_adr_nxt  = chbuf_adr;
        wr_data_nxt = chbuf_data;
        if (wr_ptr) ptr_nxt = w_data[CB_AW-1:0];
        if (wr_one || wr_inc) begin
            wr_en_nxt   = 1'b1;
            wr_adr_nxt  = ptr;
            wr_data_nxt = w_data[7:0];
        end
        if (wr_inc) ptr_nxt = ptr + 1'b1;
    end

    assign busy = 1'b0;

    // Register read decode: only the pointer is readable
    always_comb begin
        read_data = '0;
        if (r_adr == ADR_PTR) read_data = 16'(ptr);
    end
`endif

endmodule

// File: tb/tb_chbuf_ctrl.sv
// Bench for chbuf_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the register map and fill engine.
`timescale 1ns/1ps
module tb_chbuf_ctrl;
    localparam int AW   = 14;
    localparam int MASK = (1 << AW) - 1;

    logic          clk      = 1'b0;
    logic          nrst     = 1'b0;
    logic          do_write = 1'b0;
    logic [7:0]    w_adr    = 8'h00;
    logic [15:0]   w_data   = 16'h0000;
    logic [7:0]    r_adr    = 8'h00;
    logic [15:0]   read_data;
    logic          chbuf_w;
    logic [AW-1:0] chbuf_adr;
    logic [7:0]    chbuf_data;
    logic          busy;

    int vec  = 0;
    int errs = 0;

    chbuf_ctrl #(.CB_AW(AW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .do_write   (do_write),
        .w_adr      (w_adr),
        .w_data     (w_data),
        .r_adr      (r_adr),
        .read_data  (read_data),
        .chbuf_w    (chbuf_w),
        .chbuf_adr  (chbuf_adr),
        .chbuf_data (chbuf_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Monitor: log every buffer write and busy activity, sampled mid-cycle
    logic [AW+7:0] got_q[$];
    int busy_cnt = 0;
    int busy_mis = 0;
    always @(negedge clk) begin
        if (chbuf_w === 1'b1) got_q.push_back({chbuf_adr, chbuf_data});
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && chbuf_w !== 1'b1) busy_mis++;
    end

    // Behavioural model: register state plus the write expected in the
    // cycle following the most recent edge
    int         m_ptr;
    int         m_left;
    logic [7:0] m_fch;
    bit         m_ovr;
    bit         exp_w;
    bit         exp_busy;
    int         exp_adr;
    logic [7:0] exp_data;

    task automatic model_reset();
        m_ptr = 0; m_left = 0; m_fch = 8'h00; m_ovr = 0;
        exp_w = 0; exp_busy = 0; exp_adr = 0; exp_data = 8'h00;
    endtask

    task automatic model_edge(input bit dw, input logic [7:0] a, input logic [15:0] d);
        exp_w = 0;
        exp_busy = 0;
`ifdef CHBUF_FILL_EN
        if (m_left > 0) begin
            if (dw && a == 8'h07 && d[0] && m_left > 1) begin
                m_left = 0;
            end else begin
                exp_w = 1; exp_busy = 1;
                exp_adr = m_ptr; exp_data = m_fch;
                m_ptr = (m_ptr + 1) & MASK;
                m_left = m_left - 1;
            end
            if (dw && (a == 8'h00 || a == 8'h02 || a == 8'h03 || a == 8'h04 || a == 8'h05)) m_ovr = 1;
            if (dw && a == 8'h07 && d[1]) m_ovr = 0;
            return;
        end
`endif
        if (!dw) return;
        case (a)
            8'h00: m_ptr = int'(d) & MASK;
            8'h02: begin exp_w = 1; exp_adr = m_ptr; exp_data = d[7:0]; end
            8'h03: begin
                exp_w = 1; exp_adr = m_ptr; exp_data = d[7:0];
                m_ptr = (m_ptr + 1) & MASK;
            end
`ifdef CHBUF_FILL_EN
            8'h04: m_fch = d[7:0];
            8'h05: m_left = int'(d[14:0]);
            8'h07: if (d[1]) m_ovr = 0;
`endif
            default: ;
        endcase
    endtask

    function automatic logic [15:0] m_read(input logic [7:0] a);
        case (a)
            8'h00: return 16'(m_ptr);
`ifdef CHBUF_FILL_EN
            8'h04: return {8'h00, m_fch};
            8'h05: return 16'(m_left);
            8'h06: return {14'h0000, m_ovr, exp_busy};
`endif
            default: return 16'h0000;
        endcase
    endfunction

    // One clock of bus activity; the model follows the same edge
    task automatic step(input bit dw, input logic [7:0] a, input logic [15:0] d);
        do_write = dw;
        w_adr    = a;
        w_data   = d;
        @(posedge clk);
        model_edge(dw, a, d);
        #1;
        do_write = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        model_reset();
        step(1, 8'h00, 16'h1234);
        step(1, 8'h04, 16'h00A5);
        step(1, 8'h02, 16'h0077);
        #2 nrst = 1'b0;
        #1;
        model_reset();
        vec++; if (chbuf_w !== 1'b0) begin errs++; $display("FAIL reset_chbuf_w: got %0b want 0", chbuf_w); end
        vec++; if (chbuf_adr !== '0) begin errs++; $display("FAIL reset_chbuf_adr: got %h want 0", chbuf_adr); end
        vec++; if (chbuf_data !== 8'h00) begin errs++; $display("FAIL reset_chbuf_data: got %h want 00", chbuf_data); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %0b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ra;
            ra = (i == 0) ? 8'h00 : 8'(i + 3);
            r_adr = ra;
            #1;
            vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL reset_read_%h: got %h want 0000", ra, read_data); end
        end
        @(posedge clk);
        #2 nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ptr_write();
        int base;
        base = got_q.size();
        step(1, 8'h00, 16'h0100);
        step(1, 8'h03, 16'h0041);
        step(1, 8'h03, 16'h0042);
        step(1, 8'h02, 16'h0055);
        repeat (2) step(0, 8'h00, 16'h0000);
        vec++; if (got_q.size() != base + 3) begin errs++; $display("FAIL ptr_write_count: got %0d want 3", got_q.size() - base); end
        else begin
            vec++; if (got_q[base] !== {14'h0100, 8'h41}) begin errs++; $display("FAIL ptr_write_0: got %h want %h", got_q[base], {14'h0100, 8'h41}); end
            vec++; if (got_q[base+1] !== {14'h0101, 8'h42}) begin errs++; $display("FAIL ptr_write_1: got %h want %h", got_q[base+1], {14'h0101, 8'h42}); end
            vec++; if (got_q[base+2] !== {14'h0102, 8'h55}) begin errs++; $display("FAIL ptr_write_noinc: got %h want %h", got_q[base+2], {14'h0102, 8'h55}); end
        end
        r_adr = 8'h00;
        #1;
        vec++; if (read_data !== 16'h0102) begin errs++; $display("FAIL ptr_read: got %h want 0102", read_data); end
    endtask

    task automatic test_wrap();
        int base;
        base = got_q.size();
        step(1, 8'h00, 16'h3FFF);
        step(1, 8'h03, 16'h0058);
        step(0, 8'h00, 16'h0000);
        vec++; if (got_q.size() != base + 1) begin errs++; $display("FAIL wrap_count: got %0d want 1", got_q.size() - base); end
        else begin
            vec++; if (got_q[base] !== {14'h3FFF, 8'h58}) begin errs++; $display("FAIL wrap_write: got %h want %h", got_q[base], {14'h3FFF, 8'h58}); end
        end
        r_adr = 8'h00;
        #1;
        vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL wrap_ptr: got %h want 0000", read_data); end
    endtask

    task automatic test_fill();
        int base, bc, bm;
        step(1, 8'h04, 16'h0020);
        step(1, 8'h00, 16'h0010);
        base = got_q.size(); bc = busy_cnt; bm = busy_mis;
        step(1, 8'h05, 16'h8000);
        repeat (3) step(0, 8'h00, 16'h0000);
        vec++; if (got_q.size() != base) begin errs++; $display("FAIL fill_n0: got %0d writes want 0", got_q.size() - base); end
        step(1, 8'h05, 16'h0005);
        repeat (8) step(0, 8'h00, 16'h0000);
`ifdef CHBUF_FILL_EN
        vec++; if (got_q.size() != base + 5) begin errs++; $display("FAIL fill_count: got %0d want 5", got_q.size() - base); end
        else begin
            for (int i = 0; i < 5; i++) begin
                vec++; if (got_q[base+i] !== {AW'(16 + i), 8'h20}) begin errs++; $display("FAIL fill_write_%0d: got %h want %h", i, got_q[base+i], {AW'(16 + i), 8'h20}); end
            end
        end
        vec++; if (busy_cnt - bc != 5) begin errs++; $display("FAIL fill_busy_cycles: got %0d want 5", busy_cnt - bc); end
        vec++; if (busy_mis != bm) begin errs++; $display("FAIL fill_busy_align: got %0d stray want 0", busy_mis - bm); end
        r_adr = 8'h00; #1;
        vec++; if (read_data !== 16'h0015) begin errs++; $display("FAIL fill_ptr: got %h want 0015", read_data); end
        r_adr = 8'h04; #1;
        vec++; if (read_data !== 16'h0020) begin errs++; $display("FAIL fill_fch: got %h want 0020", read_data); end
        r_adr = 8'h05; #1;
        vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL fill_rem: got %h want 0000", read_data); end
`else
        vec++; if (got_q.size() != base) begin errs++; $display("FAIL nofill_count: got %0d want 0", got_q.size() - base); end
        vec++; if (busy_cnt != bc) begin errs++; $display("FAIL nofill_busy: got %0d want 0", busy_cnt - bc); end
        r_adr = 8'h00; #1;
        vec++; if (read_data !== 16'h0010) begin errs++; $display("FAIL nofill_ptr: got %h want 0010", read_data); end
        for (int i = 4; i < 7; i++) begin
            r_adr = 8'(i); #1;
            vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL nofill_read_%0d: got %h want 0000", i, read_data); end
        end
`endif
    endtask

    task automatic test_overrun();
        int base;
        step(1, 8'h00, 16'h0200);
        step(1, 8'h04, 16'h0033);
        base = got_q.size();
        step(1, 8'h05, 16'd100);
        repeat (2) step(0, 8'h00, 16'h0000);
        step(1, 8'h02, 16'h00AA);
        r_adr = 8'h06; #1;
`ifdef CHBUF_FILL_EN
        vec++; if (read_data !== 16'h0003) begin errs++; $display("FAIL ovr_during: got %h want 0003", read_data); end
        repeat (110) step(0, 8'h00, 16'h0000);
        vec++; if (got_q.size() != base + 100) begin errs++; $display("FAIL ovr_count: got %0d want 100", got_q.size() - base); end
        else begin
            for (int i = 0; i < 100; i++) begin
                vec++; if (got_q[base+i] !== {AW'(16'h0200 + i), 8'h33}) begin errs++; $display("FAIL ovr_write_%0d: got %h want %h", i, got_q[base+i], {AW'(16'h0200 + i), 8'h33}); end
            end
        end
        r_adr = 8'h06; #1;
        vec++; if (read_data !== 16'h0002) begin errs++; $display("FAIL ovr_after: got %h want 0002", read_data); end
        r_adr = 8'h00; #1;
        vec++; if (read_data !== 16'h0264) begin errs++; $display("FAIL ovr_ptr: got %h want 0264", read_data); end
        step(1, 8'h07, 16'h0002);
        r_adr = 8'h06; #1;
        vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL ovr_clear: got %h want 0000", read_data); end
`else
        vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL nofill_status: got %h want 0000", read_data); end
        step(0, 8'h00, 16'h0000);
        vec++; if (got_q.size() != base + 1) begin errs++; $display("FAIL nofill_wr_count: got %0d want 1", got_q.size() - base); end
        else begin
            vec++; if (got_q[base] !== {14'h0200, 8'hAA}) begin errs++; $display("FAIL nofill_wr: got %h want %h", got_q[base], {14'h0200, 8'hAA}); end
        end
`endif
    endtask

    task automatic test_abort();
        int base;
        step(1, 8'h00, 16'h0300);
        step(1, 8'h04, 16'h0044);
        base = got_q.size();
        step(1, 8'h05, 16'd100);
        repeat (10) step(0, 8'h00, 16'h0000);
        step(1, 8'h07, 16'h0001);
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got %0b want 0", busy); end
        repeat (3) step(0, 8'h00, 16'h0000);
`ifdef CHBUF_FILL_EN
        vec++; if (got_q.size() != base + 10) begin errs++; $display("FAIL abort_count: got %0d want 10", got_q.size() - base); end
        else begin
            vec++; if (got_q[base+9] !== {14'h0309, 8'h44}) begin errs++; $display("FAIL abort_last: got %h want %h", got_q[base+9], {14'h0309, 8'h44}); end
        end
        r_adr = 8'h05; #1;
        vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL abort_rem: got %h want 0000", read_data); end
        r_adr = 8'h00; #1;
        vec++; if (read_data !== 16'h030A) begin errs++; $display("FAIL abort_ptr: got %h want 030a", read_data); end
        r_adr = 8'h06; #1;
        vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL abort_status: got %h want 0000", read_data); end
`else
        vec++; if (got_q.size() != base) begin errs++; $display("FAIL nofill_abort_count: got %0d want 0", got_q.size() - base); end
        r_adr = 8'h00; #1;
        vec++; if (read_data !== 16'h0300) begin errs++; $display("FAIL nofill_abort_ptr: got %h want 0300", read_data); end
`endif
    endtask

    task automatic test_abort_last();
        int base;
        step(1, 8'h00, 16'h3FFE);
        step(1, 8'h04, 16'h005A);
        base = got_q.size();
        step(1, 8'h05, 16'd3);
        repeat (2) step(0, 8'h00, 16'h0000);
        step(1, 8'h07, 16'h0001);
        repeat (3) step(0, 8'h00, 16'h0000);
        r_adr = 8'h00; #1;
`ifdef CHBUF_FILL_EN
        vec++; if (got_q.size() != base + 3) begin errs++; $display("FAIL abtlast_count: got %0d want 3", got_q.size() - base); end
        else begin
            vec++; if (got_q[base+2] !== {14'h0000, 8'h5A}) begin errs++; $display("FAIL abtlast_wrap: got %h want %h", got_q[base+2], {14'h0000, 8'h5A}); end
        end
        vec++; if (read_data !== 16'h0001) begin errs++; $display("FAIL abtlast_ptr: got %h want 0001", read_data); end
`else
        vec++; if (read_data !== 16'h3FFE) begin errs++; $display("FAIL nofill_abtlast_ptr: got %h want 3ffe", read_data); end
`endif
    endtask

    task automatic test_reset_mid_fill();
        int base;
        step(1, 8'h00, 16'h0050);
        step(1, 8'h04, 16'h0011);
        base = got_q.size();
        step(1, 8'h05, 16'd50);
        repeat (20) step(0, 8'h00, 16'h0000);
`ifdef CHBUF_FILL_EN
        vec++; if (got_q.size() != base + 20) begin errs++; $display("FAIL midrst_pre: got %0d want 20", got_q.size() - base); end
`endif
        #2 nrst = 1'b0;
        #1;
        model_reset();
        vec++; if (chbuf_w !== 1'b0) begin errs++; $display("FAIL midrst_chbuf_w: got %0b want 0", chbuf_w); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        vec++; if (chbuf_adr !== '0 || chbuf_data !== 8'h00) begin errs++; $display("FAIL midrst_bus: got %h/%h want 0/0", chbuf_adr, chbuf_data); end
        r_adr = 8'h00; #1;
        vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL midrst_ptr: got %h want 0000", read_data); end
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
        @(posedge clk);
        #1;
        base = got_q.size();
        repeat (60) step(0, 8'h00, 16'h0000);
        vec++; if (got_q.size() != base) begin errs++; $display("FAIL midrst_post: got %0d writes want 0", got_q.size() - base); end
        r_adr = 8'h05; #1;
        vec++; if (read_data !== 16'h0000) begin errs++; $display("FAIL midrst_rem: got %h want 0000", read_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            bit         dw;
            int         sel;
            logic [7:0] a;
            logic [15:0] d;
            logic [7:0] ra;
            logic [15:0] exp_rd;
            dw  = ($urandom_range(0, 99) < 35);
            sel = $urandom_range(0, 9);
            case (sel)
                0: a = 8'h00;
                1: a = 8'h02;
                2: a = 8'h03;
                3: a = 8'h03;
                4: a = 8'h04;
                5: a = 8'h05;
                6: a = 8'h07;
                7: a = 8'h06;
                8: a = 8'h01;
                default: a = 8'($urandom);
            endcase
            d = 16'($urandom);
            if (a == 8'h05) d = {d[15], 15'($urandom_range(0, 12))};
            if (a == 8'h07 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            if (a == 8'h00 && $urandom_range(0, 3) == 0) d = 16'(MASK - $urandom_range(0, 2));
            step(dw, a, d);
            case ($urandom_range(0, 5))
                0: ra = 8'h00;
                1: ra = 8'h04;
                2: ra = 8'h05;
                3: ra = 8'h06;
                4: ra = 8'h07;
                default: ra = 8'($urandom);
            endcase
            r_adr = ra;
            #1;
            exp_rd = m_read(ra);
            vec++; if (chbuf_w !== exp_w) begin errs++; $display("FAIL rnd_chbuf_w @%0d: got %0b want %0b", i, chbuf_w, exp_w); end
            vec++; if (busy !== exp_busy) begin errs++; $display("FAIL rnd_busy @%0d: got %0b want %0b", i, busy, exp_busy); end
            if (exp_w) begin
                vec++; if (chbuf_adr !== AW'(exp_adr) || chbuf_data !== exp_data) begin
                    errs++; $display("FAIL rnd_write @%0d: got %h/%h want %h/%h", i, chbuf_adr, chbuf_data, AW'(exp_adr), exp_data);
                end
            end
            vec++; if (read_data !== exp_rd) begin errs++; $display("FAIL rnd_read_%h @%0d: got %h want %h", ra, i, read_data, exp_rd); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_ptr_write();
        test_wrap();
        test_fill();
        test_overrun();
        test_abort();
        test_abort_last();
        test_reset_mid_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/chbuf_ctrl.md
CHBUF_CTRL -- requirements
Module: chbuf_ctrl

Interface
REQ-001 SHALL have parameter CB_AW, default 14: character-buffer address width.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port do_write  input  1  one-cycle bus write strobe.
REQ-005 SHALL have port w_adr  input  8  bus write register address.
REQ-006 SHALL have port w_data  input  16  bus write data.
REQ-007 SHALL have port r_adr  input  8  bus read register address.
REQ-008 SHALL have port read_data  output  16  combinational read decode of r_adr.
REQ-009 SHALL have port chbuf_w  output  1  char-buffer write enable, registered.
REQ-010 SHALL have port chbuf_adr  output  CB_AW  char-buffer write address, registered.
REQ-011 SHALL have port chbuf_data  output  8  char-buffer write data, registered.
REQ-012 SHALL have port busy  output  1  fill engine active.

Function
REQ-013 SHALL hold pointer ptr (CB_AW bits), fill char fch (8), remaining count rem (15), sticky overrun flag ovr; ptr wraps 2^CB_AW-1 -> 0.
REQ-014 SHALL implement states IDLE and FILL; all writes act on the rising edge after do_write (latency 1).
REQ-015 IDLE, w_adr 0x00: ptr <= w_data[CB_AW-1:0]; no buffer write.
REQ-016 IDLE, w_adr 0x02: one-cycle chbuf_w=1, chbuf_adr=ptr, chbuf_data=w_data[7:0]; ptr unchanged.
REQ-017 IDLE, w_adr 0x03: as REQ-016, plus ptr <= ptr+1 on the same edge.
REQ-018 IDLE, w_adr 0x04: fch <= w_data[7:0].
REQ-019 IDLE, w_adr 0x05, N=w_data[14:0]: N=0 -> no effect; N>0 -> enter FILL, rem <= N.
REQ-020 FILL: each cycle chbuf_w=1, chbuf_adr=ptr, chbuf_data=fch, ptr+1, rem-1; exactly N consecutive writes at ptr0..ptr0+N-1 (mod 2^CB_AW); IDLE when rem reaches 0.
REQ-021 busy SHALL equal 1 exactly in the N cycles chbuf_w is asserted by the fill; 0 at the following edge.
REQ-022 FILL, do_write to 0x00/0x02/0x03/0x04/0x05: write discarded, ovr <= 1; fill continues unaffected.
REQ-023 w_adr 0x07 (CTRL) accepted in any state: w_data[0]=1 aborts fill (no chbuf_w after that edge, rem <= 0, IDLE, ptr keeps advanced value); w_data[1]=1 clears ovr.
REQ-024 Abort coinciding with final fill write SHALL yield the same result as normal completion; ovr set and clear in same cycle -> clear wins.
REQ-025 Writes to undefined addresses SHALL be ignored in all states.
REQ-026 read_data: 0x00 -> ptr zero-extended; 0x04 -> {8'h0,fch}; 0x05 -> {1'b0,rem}; 0x06 -> {14'h0,ovr,busy}; others -> 0; reads have no side effects.
REQ-027 chbuf_w SHALL be 0 in every cycle not defined above.

Reset
REQ-028 nrst low SHALL immediately force IDLE, ptr=0, fch=0x00, rem=0, ovr=0, chbuf_w=0, chbuf_adr=0, chbuf_data=0, busy=0.
REQ-029 Reset mid-fill SHALL terminate the fill with no further writes after release.

Configuration
REQ-030 Macro CHBUF_FILL_EN defined: fill engine present per REQ-018..REQ-024.
REQ-031 CHBUF_FILL_EN undefined: no FILL state, fch/rem/ovr removed; 0x04/0x05/0x07 ignored; busy tied 0; reads 0x04/0x05/0x06 return 0.

Verification
REQ-032 Write 0x00=0x0100, 0x03=0x41, 0x03=0x42 -> chbuf writes (0x100,0x41),(0x101,0x42); ptr read 0x0102.
REQ-033 Write 0x00=0x3FFF, 0x03=0x58 -> write at 0x3FFF; ptr reads 0x0000.
REQ-034 Write 0x04=0x20, 0x00=0x10, 0x05=5 -> 5 consecutive writes 0x10..0x14 data 0x20, busy high 5 cycles, ptr 0x15.
REQ-035 Fill N=100, bus write 0x02 at fill cycle 3 -> no extra write, status reads 0x0003 during fill, 0x0002 after; write 0x07=2 -> 0x0000.
REQ-036 Fill N=100, write 0x07=1 at cycle 10 -> exactly 10 writes, busy low next cycle, rem reads 0.
REQ-037 Fill N=50, nrst low at cycle 20 -> all outputs 0 immediately, no writes after release, ptr 0.
